// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Valid/ready load-stream bundle between a word source and the
//               program loader.
//   s_valid   source -> loader  beat valid
//   s_ready   loader -> source  loader can accept a beat
//   s_data    source -> loader  beat payload (DATA_W bits)
//   s_target  source -> loader  0 = instruction memory, 1 = register file
//   s_last    source -> loader  final beat of the load
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int DATA_W = 32
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_target;
    logic              s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_target,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_target,
        input  s_last,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Program loader and reset sequencer for the single-cycle
//               RISC-V core. Streams words into instruction memory or the
//               register file, holds the core in reset until loading is done
//               plus RST_HOLD settling cycles, then counts run cycles and
//               flags halt at RUN_LIMIT (0 = unlimited).
//   clk, rst           clock, synchronous active-high reset
//   strm               load stream (slave side of prog_loader_if)
//   reload             one-cycle request to restart loading while running
//   imem_we/addr/wdata registered instruction-memory write port
//   rf_we/addr/wdata   registered register-file write port
//   core_rst           reset to the core (high outside RUN)
//   done               high while in RUN
//   err                sticky: a beat was dropped because its target was full
//   cycle_cnt          cycles spent in RUN
//   halt               cycle_cnt has reached RUN_LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int          DATA_W    = 32,
    parameter int          IMEM_AW   = 8,
    parameter int          RF_AW     = 5,
    parameter int          RST_HOLD  = 2,
    parameter int unsigned RUN_LIMIT = 100
) (
    input  wire logic               clk,
    input  wire logic               rst,
    prog_loader_if.slave            strm,
    input  wire logic               reload,
    output logic                    imem_we,
    output logic [IMEM_AW-1:0]      imem_addr,
    output logic [DATA_W-1:0]       imem_wdata,
    output logic                    rf_we,
    output logic [RF_AW-1:0]        rf_addr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    core_rst,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             cycle_cnt,
    output logic                    halt
);
    localparam int              HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
    localparam logic [31:0]     LIMIT     = 32'(RUN_LIMIT);
    localparam logic [IMEM_AW:0] IMEM_ONE = {{IMEM_AW{1'b0}}, 1'b1};
    localparam logic [RF_AW:0]  RF_ONE    = {{RF_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [IMEM_AW:0]    r_imem_cnt;
    logic [RF_AW:0]      r_rf_cnt;
    logic                r_imem_we;
    logic [IMEM_AW-1:0]  r_imem_addr;
    logic [DATA_W-1:0]   r_imem_wdata;
    logic                r_rf_we;
    logic [RF_AW-1:0]    r_rf_addr;
    logic [DATA_W-1:0]   r_rf_wdata;
    logic                r_err;
    logic [31:0]         r_cycle_cnt;

    // A counter is full when its MSB is set: it then equals the depth exactly.
    logic w_imem_full;
    logic w_rf_full;
    logic w_imem_wr;
    logic w_rf_wr;
    logic w_drop;
    logic w_halt;

    assign w_imem_full = r_imem_cnt[IMEM_AW];
    assign w_rf_full   = r_rf_cnt[RF_AW];
    assign w_imem_wr   = w_accept & ~strm.s_target & ~w_imem_full;
    assign w_rf_wr     = w_accept &  strm.s_target & ~w_rf_full;
    assign w_drop      = w_accept & (strm.s_target ? w_rf_full : w_imem_full);
    assign w_halt      = (LIMIT != 32'd0) && (r_cycle_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_accept = strm.s_valid;
                if (strm.s_valid && strm.s_last) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt   <= '0;
            r_imem_cnt   <= '0;
            r_rf_cnt     <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_rf_we      <= 1'b0;
            r_rf_addr    <= '0;
            r_rf_wdata   <= '0;
            r_err        <= 1'b0;
            r_cycle_cnt  <= '0;
        end else begin
            r_imem_we <= w_imem_wr;
            r_rf_we   <= w_rf_wr;
            if (w_imem_wr) begin
                r_imem_addr  <= r_imem_cnt[IMEM_AW-1:0];
                r_imem_wdata <= strm.s_data;
                r_imem_cnt   <= r_imem_cnt + IMEM_ONE;
            end
            if (w_rf_wr) begin
                r_rf_addr  <= r_rf_cnt[RF_AW-1:0];
                r_rf_wdata <= strm.s_data;
                r_rf_cnt   <= r_rf_cnt + RF_ONE;
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end

            // Settling counter is armed on the last beat and runs down in HOLD.
            if (r_state == ST_LOAD && w_state_next == ST_HOLD) begin
                r_hold_cnt <= HOLD_INIT;
            end else if (r_state == ST_HOLD && r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end

            // Clearing cycle_cnt on reload also drops halt, which is derived
            // from it. Unlimited mode wraps naturally at 2^32.
            if (r_state == ST_RUN) begin
                if (reload) begin
                    r_imem_cnt  <= '0;
                    r_rf_cnt    <= '0;
                    r_cycle_cnt <= '0;
                end else if (!w_halt) begin
                    r_cycle_cnt <= r_cycle_cnt + 32'd1;
                end
            end
        end
    end

    assign strm.s_ready = (r_state == ST_LOAD);
    assign core_rst     = (r_state != ST_RUN);
    assign done         = (r_state == ST_RUN);
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign rf_we        = r_rf_we;
    assign rf_addr      = r_rf_addr;
    assign rf_wdata     = r_rf_wdata;
    assign err          = r_err;
    assign cycle_cnt    = r_cycle_cnt;
    assign halt         = w_halt;
endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. A small DUT (4-entry
//               imem and register file, RST_HOLD=3, RUN_LIMIT=10) is driven
//               with fixed and random load streams; a twin with RUN_LIMIT=0
//               shares the stimulus to cover the unlimited run counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
    localparam int IMEM_AW = 2;
    localparam int RF_AW   = 2;
    localparam int IDEPTH  = 1 << IMEM_AW;
    localparam int RDEPTH  = 1 << RF_AW;
    localparam int HOLD    = 3;
    localparam int LIMIT   = 10;

    logic clk;
    logic rst;
    logic reload;

    logic               imem_we,  imem_we2;
    logic [IMEM_AW-1:0] imem_addr, imem_addr2;
    logic [31:0]        imem_wdata, imem_wdata2;
    logic               rf_we, rf_we2;
    logic [RF_AW-1:0]   rf_addr, rf_addr2;
    logic [31:0]        rf_wdata, rf_wdata2;
    logic               core_rst, core_rst2;
    logic               done, done2;
    logic               err, err2;
    logic [31:0]        cycle_cnt, cycle_cnt2;
    logic               halt, halt2;

    prog_loader_if #(.DATA_W(32)) u_if ();
    prog_loader_if #(.DATA_W(32)) u_if2 ();

    assign u_if2.s_valid  = u_if.s_valid;
    assign u_if2.s_data   = u_if.s_data;
    assign u_if2.s_target = u_if.s_target;
    assign u_if2.s_last   = u_if.s_last;

    prog_loader #(.DATA_W(32), .IMEM_AW(IMEM_AW), .RF_AW(RF_AW),
                  .RST_HOLD(HOLD), .RUN_LIMIT(LIMIT)) u_dut (
        .clk(clk), .rst(rst), .strm(u_if.slave), .reload(reload),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .core_rst(core_rst), .done(done), .err(err),
        .cycle_cnt(cycle_cnt), .halt(halt)
    );

    prog_loader #(.DATA_W(32), .IMEM_AW(IMEM_AW), .RF_AW(RF_AW),
                  .RST_HOLD(HOLD), .RUN_LIMIT(0)) u_dut_unl (
        .clk(clk), .rst(rst), .strm(u_if2.slave), .reload(reload),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .rf_we(rf_we2), .rf_addr(rf_addr2), .rf_wdata(rf_wdata2),
        .core_rst(core_rst2), .done(done2), .err(err2),
        .cycle_cnt(cycle_cnt2), .halt(halt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          tgt;
        int          addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    wr_t act_q[$];
    wr_t exp_q[$];

    // Every observed write, tagged with the cycle it was visible in.
    always @(negedge clk) begin
        wr_t w;
        if (imem_we === 1'b1) begin
            w.tgt = 1'b0; w.addr = int'(imem_addr); w.data = imem_wdata; w.at = cyc;
            act_q.push_back(w);
        end
        if (rf_we === 1'b1) begin
            w.tgt = 1'b1; w.addr = int'(rf_addr); w.data = rf_wdata; w.at = cyc;
            act_q.push_back(w);
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: per-target fill levels, sticky drop flag, run count.
    int imem_n  = 0;
    int rf_n    = 0;
    bit err_exp = 1'b0;
    int run_k   = 0;

    bit          beat_tgt[$];
    logic [31:0] beat_dat[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        imem_n = 0; rf_n = 0; err_exp = 1'b0; run_k = 0;
    endtask

    // A beat presented now is accepted at the coming edge; its write is
    // visible in the following cycle, or it is dropped if the target is full.
    task automatic model_accept(input bit tgt, input logic [31:0] d);
        wr_t w;
        w.tgt = tgt; w.data = d; w.at = cyc + 1;
        if (!tgt) begin
            if (imem_n < IDEPTH) begin w.addr = imem_n; imem_n++; exp_q.push_back(w); end
            else err_exp = 1'b1;
        end else begin
            if (rf_n < RDEPTH) begin w.addr = rf_n; rf_n++; exp_q.push_back(w); end
            else err_exp = 1'b1;
        end
    endtask

    task automatic compare_writes();
        int n;
        check_val("n_writes", 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val("wr_target", 64'(act_q[i].tgt),  64'(exp_q[i].tgt));
            check_val("wr_addr",   64'(act_q[i].addr), 64'(exp_q[i].addr));
            check_val("wr_data",   64'(act_q[i].data), 64'(exp_q[i].data));
            check_val("wr_cycle",  64'(act_q[i].at),   64'(exp_q[i].at));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_vals();
        check_val("rst_core_rst", 64'(core_rst),   64'd1);
        check_val("rst_s_ready",  64'(u_if.s_ready), 64'd1);
        check_val("rst_done",     64'(done),       64'd0);
        check_val("rst_err",      64'(err),        64'd0);
        check_val("rst_halt",     64'(halt),       64'd0);
        check_val("rst_imem_we",  64'(imem_we),    64'd0);
        check_val("rst_rf_we",    64'(rf_we),      64'd0);
        check_val("rst_cycle",    64'(cycle_cnt),  64'd0);
        check_val("rst_imem_a",   64'(imem_addr),  64'd0);
        check_val("rst_imem_d",   64'(imem_wdata), 64'd0);
        check_val("rst_rf_a",     64'(rf_addr),    64'd0);
        check_val("rst_rf_d",     64'(rf_wdata),   64'd0);
    endtask

    // Streams beat_tgt/beat_dat, optionally with random idle gaps. Stray
    // reload pulses during LOAD must have no effect.
    task automatic drive_load(input bit gaps);
        int nb = beat_dat.size();
        for (int i = 0; i < nb; i++) begin
            int gap = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (gap) begin
                u_if.s_valid  = 1'b0;
                u_if.s_data   = $urandom;
                u_if.s_target = 1'($urandom);
                u_if.s_last   = 1'($urandom);
                reload        = 1'($urandom);
                step();
            end
            u_if.s_valid  = 1'b1;
            u_if.s_data   = beat_dat[i];
            u_if.s_target = beat_tgt[i];
            u_if.s_last   = (i == nb - 1);
            reload        = gaps ? 1'($urandom) : 1'b0;
            check_val("s_ready_load", 64'(u_if.s_ready), 64'd1);
            model_accept(beat_tgt[i], beat_dat[i]);
            step();
        end
        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;
        reload       = 1'b0;
        beat_tgt.delete();
        beat_dat.delete();
    endtask

    // Called in the cycle after the last beat; RUN must begin HOLD cycles later.
    task automatic wait_run();
        int k = 0;
        while (done !== 1'b1 && k < 20) begin
            check_val("hold_core_rst", 64'(core_rst), 64'd1);
            check_val("hold_s_ready",  64'(u_if.s_ready), 64'd0);
            reload = 1'($urandom);
            step();
            k++;
        end
        reload = 1'b0;
        check_val("hold_len",      64'(k),         64'(HOLD));
        check_val("run_core_rst",  64'(core_rst),  64'd0);
        check_val("run_s_ready",   64'(u_if.s_ready), 64'd0);
        check_val("run_cycle0",    64'(cycle_cnt), 64'd0);
        check_val("run_err",       64'(err),       64'(err_exp));
        run_k = 0;
    endtask

    task automatic run_cycles(input int m);
        for (int j = 0; j < m; j++) begin
            int exp_c;
            step();
            run_k++;
            exp_c = (run_k >= LIMIT) ? LIMIT : run_k;
            check_val("cycle_cnt",  64'(cycle_cnt),  64'(exp_c));
            check_val("halt",       64'(halt),       64'(exp_c == LIMIT));
            check_val("cycle_unl",  64'(cycle_cnt2), 64'(run_k));
            check_val("halt_unl",   64'(halt2),      64'd0);
            check_val("run_done",   64'(done),       64'd1);
            check_val("run_err_st", 64'(err),        64'(err_exp));
            check_val("run_no_wr",  64'(imem_we | rf_we), 64'd0);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
        check_val("rl_core_rst", 64'(core_rst),   64'd1);
        check_val("rl_s_ready",  64'(u_if.s_ready), 64'd1);
        check_val("rl_done",     64'(done),       64'd0);
        check_val("rl_cycle",    64'(cycle_cnt),  64'd0);
        check_val("rl_halt",     64'(halt),       64'd0);
        check_val("rl_err",      64'(err),        64'(err_exp));
        imem_n = 0;
        rf_n   = 0;
    endtask

    initial begin
        u_if.s_valid  = 1'b0;
        u_if.s_data   = '0;
        u_if.s_target = 1'b0;
        u_if.s_last   = 1'b0;
        reload        = 1'b0;
        rst           = 1'b1;
        repeat (3) step();
        check_reset_vals();
        rst = 1'b0;
        model_reset();
        act_q.delete();

        // Basic load of three instruction words, no gaps.
        beat_tgt = '{1'b0, 1'b0, 1'b0};
        beat_dat = '{32'h0020_0193, 32'h0030_8233, 32'h0000_006F};
        drive_load(1'b0);
        wait_run();
        compare_writes();
        run_cycles(4);

        // Reload at cycle_cnt = 4, then a single beat lands at imem 0.
        do_reload();
        beat_tgt = '{1'b0};
        beat_dat = '{$urandom};
        drive_load(1'b1);
        wait_run();
        compare_writes();
        run_cycles(13);
        do_reload();

        // Interleaved targets with idle gaps.
        beat_tgt = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        beat_dat = '{$urandom, 32'd5, $urandom, 32'd7, $urandom};
        drive_load(1'b1);
        wait_run();
        compare_writes();
        run_cycles(int'($urandom_range(0, 12)));
        do_reload();

        // Overflow: five imem beats into a four-entry memory.
        for (int i = 0; i < 5; i++) begin
            beat_tgt.push_back(1'b0);
            beat_dat.push_back($urandom);
        end
        drive_load(1'b1);
        wait_run();
        compare_writes();
        run_cycles(3);
        do_reload();

        // Random streams of mixed targets.
        for (int it = 0; it < 10; it++) begin
            int nb = int'($urandom_range(1, 9));
            for (int i = 0; i < nb; i++) begin
                beat_tgt.push_back(1'($urandom));
                beat_dat.push_back($urandom);
            end
            drive_load(1'b1);
            wait_run();
            compare_writes();
            run_cycles(int'($urandom_range(0, 14)));
            do_reload();
        end

        // Reset during HOLD.
        beat_tgt = '{1'b1, 1'b0};
        beat_dat = '{$urandom, $urandom};
        drive_load(1'b0);
        rst = 1'b1;
        step();
        check_reset_vals();
        rst = 1'b0;
        compare_writes();
        model_reset();

        // Reset at the edge that would accept a beat: its write is dropped.
        u_if.s_valid  = 1'b1;
        u_if.s_target = 1'b0;
        u_if.s_data   = $urandom;
        u_if.s_last   = 1'b0;
        rst           = 1'b1;
        step();
        check_reset_vals();
        rst          = 1'b0;
        u_if.s_valid = 1'b0;
        step();
        check_val("post_rst_we", 64'(imem_we | rf_we), 64'd0);
        compare_writes();

        // Counters restart at 0 after reset.
        beat_tgt = '{1'b0};
        beat_dat = '{$urandom};
        drive_load(1'b0);
        wait_run();
        compare_writes();
        run_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
